coin_input_conditioner: RTL and testbench

- Front-end stage feeding the vending machine FSM.
- Takes the two raw, bouncy, asynchronous coin-acceptor switch lines (one-yuan, half-yuan).
- Synchronises and debounces each line and emits clean, single-cycle, mutually exclusive credit pulses.
- These pulses connect directly to the FSM's piOne/piHalf inputs.

---
 rtl/coin_input_conditioner.sv | 135 +++++++++++++
 tb/tb_coin_input_conditioner.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/coin_input_conditioner.sv
// Coin-acceptor front end: two-flop synchronisers, per-channel debounce FSMs
// and arbitration into mutually exclusive single-cycle credit pulses.
module coin_input_conditioner #(
    parameter int                CNT_W   = 20,
    parameter logic [CNT_W-1:0]  CNT_MAX = 20'd999_999
) (
    input  logic sys_clk,
    input  logic sysRstN,
    input  logic iCoinOne,
    input  logic iCoinHalf,
    output logic piOne,
    output logic piHalf,
    output logic oBusy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FILT_ON  = 2'd1,
        HELD     = 2'd2,
        FILT_OFF = 2'd3
    } chan_state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Bit 0 is the one-yuan channel, bit 1 the half-yuan channel.
    logic [1:0] raw;
    logic [1:0] s1_q;
    logic [1:0] s2_q;
    logic [1:0] req;
    logic [1:0] busy;

    assign raw = {iCoinHalf, iCoinOne};

    always_ff @(posedge sys_clk) begin
        if (!sysRstN) begin
            s1_q <= 2'b00;
            s2_q <= 2'b00;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            chan_state_t      state_q;
            chan_state_t      state_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             req_c;

            always_ff @(posedge sys_clk) begin
                if (!sysRstN) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                req_c   = 1'b0;
                case (state_q)
                    IDLE: begin
                        if (s2_q[gi]) begin
                            state_d = FILT_ON;
                            cnt_d   = '0;
                        end
                    end
                    FILT_ON: begin
                        if (!s2_q[gi]) begin
                            state_d = IDLE;
                        end else if (cnt_q < CNT_MAX) begin
                            cnt_d = cnt_q + CNT_ONE;
                        end else begin
                            state_d = HELD;
                            req_c   = 1'b1;
                        end
                    end
                    HELD: begin
                        if (!s2_q[gi]) begin
                            state_d = FILT_OFF;
                            cnt_d   = '0;
                        end
                    end
                    FILT_OFF: begin
                        // A high blip during release is bounce: go back to HELD, no new credit.
                        if (s2_q[gi]) begin
                            state_d = HELD;
                        end else if (cnt_q < CNT_MAX) begin
                            cnt_d = cnt_q + CNT_ONE;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            assign req[gi]  = req_c;
            assign busy[gi] = (state_q != IDLE);
        end
    endgenerate

    logic pi_one_q;
    logic pi_half_q;
    logic pending_q;
    logic busy_q;

    // Simultaneous requests: one-yuan wins this edge, half-yuan is deferred one cycle.
    always_ff @(posedge sys_clk) begin
        if (!sysRstN) begin
            pi_one_q  <= 1'b0;
            pi_half_q <= 1'b0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            pi_one_q  <= req[0];
            pi_half_q <= pending_q | (req[1] & ~req[0]);
            pending_q <= req[0] & req[1];
            busy_q    <= |busy;
        end
    end

    assign piOne  = pi_one_q;
    assign piHalf = pi_half_q;
    assign oBusy  = busy_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner with CNT_MAX=3: a scoreboard of
// expected pulse cycles is checked every cycle, plus a small vending model.
module tb_coin_input_conditioner;

    logic sys_clk = 1'b0;
    logic sysRstN;
    logic iCoinOne;
    logic iCoinHalf;
    logic piOne;
    logic piHalf;
    logic oBusy;

    coin_input_conditioner #(
        .CNT_W   (20),
        .CNT_MAX (20'd3)
    ) dut (
        .sys_clk   (sys_clk),
        .sysRstN   (sysRstN),
        .iCoinOne  (iCoinOne),
        .iCoinHalf (iCoinHalf),
        .piOne     (piOne),
        .piHalf    (piHalf),
        .oBusy     (oBusy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int cyc;
        bit is_half;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   credits  = 0;
    int   halves   = 0;
    int   colas    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Raw input driven now is first sampled at edge cyc+1; the pulse is set CNT_MAX+3 edges later.
    task automatic expect_pulse(input bit is_half);
        exp_t e;
        e.cyc     = cyc + 7;
        e.is_half = is_half;
        sbq.push_back(e);
    endtask

    task automatic step();
        logic exp_one;
        logic exp_half;
        @(posedge sys_clk);
        #1;
        cyc++;
        exp_one  = 1'b0;
        exp_half = 1'b0;
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            if (sbq[0].is_half) exp_half = 1'b1;
            else                exp_one  = 1'b1;
            void'(sbq.pop_front());
        end
        check("piOne", {31'd0, piOne}, {31'd0, exp_one});
        check("piHalf", {31'd0, piHalf}, {31'd0, exp_half});
        check("exclusive", {31'd0, piOne & piHalf}, 32'd0);
        if (piOne === 1'b1)  begin credits++; halves += 2; end
        if (piHalf === 1'b1) begin credits++; halves += 1; end
        if (halves >= 5) begin colas++; halves -= 5; end
        $display("cyc=%0d one=%0b half=%0b busy=%0b", cyc, piOne, piHalf, oBusy);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        sysRstN   = 1'b0;
        iCoinOne  = 1'b0;
        iCoinHalf = 1'b0;

        // 1: reset, then a clean long one-yuan press
        steps(2);
        check("reset_busy", {31'd0, oBusy}, 32'd0);
        sysRstN = 1'b1;
        steps(2);
        iCoinOne = 1'b1;
        expect_pulse(1'b0);
        steps(5);
        check("busy_qualifying", {31'd0, oBusy}, 32'd1);
        steps(15);
        iCoinOne = 1'b0;
        steps(12);
        check("busy_idle_t1", {31'd0, oBusy}, 32'd0);

        // 2: toggling half-yuan, then held
        iCoinHalf = 1'b1; step();
        iCoinHalf = 1'b0; step();
        iCoinHalf = 1'b1; step();
        iCoinHalf = 1'b0; step();
        iCoinHalf = 1'b1;
        expect_pulse(1'b1);
        steps(12);
        iCoinHalf = 1'b0;
        steps(12);
        check("busy_idle_t2", {31'd0, oBusy}, 32'd0);

        // 3: both coins on the same cycle
        iCoinOne  = 1'b1;
        iCoinHalf = 1'b1;
        expect_pulse(1'b0);
        begin
            exp_t e;
            e.cyc     = cyc + 8;
            e.is_half = 1'b1;
            sbq.push_back(e);
        end
        steps(12);
        iCoinOne  = 1'b0;
        iCoinHalf = 1'b0;
        steps(12);

        // 4: bouncy release, then re-insert
        iCoinOne = 1'b1;
        expect_pulse(1'b0);
        steps(10);
        iCoinOne = 1'b0; step();
        iCoinOne = 1'b1; steps(2);
        iCoinOne = 1'b0;
        steps(12);
        check("busy_between", {31'd0, oBusy}, 32'd0);
        iCoinOne = 1'b1;
        expect_pulse(1'b0);
        steps(10);
        iCoinOne = 1'b0;
        steps(12);

        // 5: reset mid-qualification (cnt=2), input still held
        iCoinOne = 1'b1;
        steps(5);
        sysRstN = 1'b0;
        step();
        check("rst_busy", {31'd0, oBusy}, 32'd0);
        sysRstN = 1'b1;
        expect_pulse(1'b0);
        steps(10);
        iCoinOne = 1'b0;
        steps(12);

        // 6: three halves then one yuan into a 2.5-yuan vending model
        credits = 0;
        halves  = 0;
        colas   = 0;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) iCoinHalf = 1'b1;
            else       iCoinOne  = 1'b1;
            expect_pulse(k < 3);
            steps(10);
            iCoinHalf = 1'b0;
            iCoinOne  = 1'b0;
            steps(12);
        end
        check("credits", credits, 32'd4);
        check("cola_count", colas, 32'd1);
        check("scoreboard_empty", sbq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
